// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
// Holds the FSM encoding, the access-kind enum, byte lanes and control-word bit positions.
package mem_stage_pkg;

  localparam int CTRL_W = 33;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  typedef enum logic [1:0] {
    ACC_NONE = 2'd0,
    ACC_BYTE = 2'd1,
    ACC_WORD = 2'd2
  } acc_kind_t;

  localparam logic LANE_LO = 1'b0;
  localparam logic LANE_HI = 1'b1;

  // Low bits of the control word carry the fields this stage cares about.
  localparam int CW_REG_ADDR    = 0;
  localparam int CW_MEM_READ_B  = 3;
  localparam int CW_MEM_READ_W  = 4;
  localparam int CW_MEM_WRITE_B = 5;
  localparam int CW_MEM_WRITE_W = 6;
  localparam int CW_FIELDS_W    = 7;

  function automatic logic is_write(input logic wb, input logic ww);
    return wb | ww;
  endfunction

  // Writes win over reads, and word accesses win over byte accesses.
  function automatic acc_kind_t acc_kind(input logic rb, input logic rw,
                                         input logic wb, input logic ww);
    if (wb | ww) return ww ? ACC_WORD : ACC_BYTE;
    if (rb | rw) return rw ? ACC_WORD : ACC_BYTE;
    return ACC_NONE;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Extracts the address-register select and memory flags from the control word.
// Purely combinational; no latency, no flow control.
module ctrl_decode
  import mem_stage_pkg::*;
(
  input  logic [CW_FIELDS_W-1:0] ctrl_fields,
  output logic [2:0]             reg_addr,
  output logic                   mem_read_b,
  output logic                   mem_read_w,
  output logic                   mem_write_b,
  output logic                   mem_write_w
);

  assign reg_addr    = ctrl_fields[CW_REG_ADDR +: 3];
  assign mem_read_b  = ctrl_fields[CW_MEM_READ_B];
  assign mem_read_w  = ctrl_fields[CW_MEM_READ_W];
  assign mem_write_b = ctrl_fields[CW_MEM_WRITE_B];
  assign mem_write_w = ctrl_fields[CW_MEM_WRITE_W];

endmodule

// File: rtl/mem_stage_byte_xfer.sv
// One byte transfer on the req/ack bus: lane-selected address/data plus a wait counter with timeout.
// Bus outputs are combinational from the sequencer state; aborts after WAIT_LIMIT ack-less cycles.
module mem_byte_xfer
  import mem_stage_pkg::*;
#(
  parameter int WAIT_LIMIT = 255,
  parameter int CNT_W      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        active,
  input  logic        lane,
  input  logic        we,
  input  logic [15:0] base_addr,
  input  logic [15:0] data,
  input  logic        bus_ack,
  output logic        bus_req,
  output logic        bus_we,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        done,
  output logic        timeout
);

  localparam int LIMIT_M1 = (WAIT_LIMIT == 0) ? 0 : WAIT_LIMIT - 1;
  localparam logic [CNT_W-1:0] LAST_WAIT = LIMIT_M1[CNT_W-1:0];
  localparam logic TIMEOUT_EN = (WAIT_LIMIT != 0);

  logic [CNT_W-1:0] wait_cnt;

  assign bus_req   = active;
  assign bus_we    = active & we;
  assign bus_addr  = !active ? 16'h0000 : (lane == LANE_HI) ? base_addr + 16'd1 : base_addr;
  assign bus_wdata = !active ? 8'h00 : (lane == LANE_HI) ? data[15:8] : data[7:0];
  assign done      = active & bus_ack;

  // Firing on the last ack-less cycle means WAIT_LIMIT request cycles were seen.
  assign timeout = TIMEOUT_EN & active & ~bus_ack & (wait_cnt == LAST_WAIT);

  always_ff @(posedge clk) begin
    if (reset || !active || bus_ack) begin
      wait_cnt <= '0;
    end else if (wait_cnt != {CNT_W{1'b1}}) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: does the data-memory access as 1-2 byte transfers and pulses out_valid to writeback.
// Latency 1 (no mem) / 2 (byte) / 3 (word) cycles with immediate acks; in_ready low outside IDLE.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int WAIT_LIMIT = 255,
  parameter int CNT_W      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [32:0] control_signals_in,
  input  logic [15:0] imm_in,
  input  logic [15:0] pc_in,
  input  logic [15:0] alu_result_in,
  output logic [2:0]  rf_regAddr,
  input  logic [15:0] rf_addrData,
  output logic        bus_req,
  output logic        bus_we,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  input  logic        bus_ack,
  output logic        out_valid,
  output logic [32:0] control_signals_out,
  output logic [15:0] imm_out,
  output logic [15:0] pc_out,
  output logic [15:0] alu_result_out,
  output logic [15:0] mem_rdata_out,
  output logic        bus_err_out
);

  logic [1:0]  state, state_nxt;
  logic [32:0] ctrl_q;
  logic [15:0] imm_q, pc_q, data_q, addr_q;
  logic [7:0]  rdata_lo;
  acc_kind_t   kind_q, in_kind;
  logic        we_q, in_we;

  logic [2:0]  dec_reg_addr;
  logic        dec_rb, dec_rw, dec_wb, dec_ww;
  logic        accept, active, lane, xfer_done, xfer_timeout;
  logic        load_out, from_in, err_nxt;
  logic [15:0] rdata_nxt;

  ctrl_decode u_dec (
    .ctrl_fields (control_signals_in[CW_FIELDS_W-1:0]),
    .reg_addr    (dec_reg_addr),
    .mem_read_b  (dec_rb),
    .mem_read_w  (dec_rw),
    .mem_write_b (dec_wb),
    .mem_write_w (dec_ww)
  );

  assign rf_regAddr = reset ? 3'd0 : dec_reg_addr;
  assign in_ready   = (state == S_IDLE) && !reset;
  assign accept     = in_valid && in_ready;
  assign in_kind    = acc_kind(dec_rb, dec_rw, dec_wb, dec_ww);
  assign in_we      = is_write(dec_wb, dec_ww);
  assign active     = (state == S_LO) || (state == S_HI);
  assign lane       = (state == S_HI) ? LANE_HI : LANE_LO;
  assign out_valid  = (state == S_DONE);

  mem_byte_xfer #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(CNT_W)) u_xfer (
    .clk       (clk),
    .reset     (reset),
    .active    (active),
    .lane      (lane),
    .we        (we_q),
    .base_addr (addr_q),
    .data      (data_q),
    .bus_ack   (bus_ack),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .done      (xfer_done),
    .timeout   (xfer_timeout)
  );

  // load_out marks the edge into DONE, where the writeback-facing registers update.
  always_comb begin
    state_nxt = state;
    load_out  = 1'b0;
    from_in   = 1'b0;
    err_nxt   = 1'b0;
    rdata_nxt = 16'h0000;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (in_kind == ACC_NONE) begin
            state_nxt = S_DONE;
            load_out  = 1'b1;
            from_in   = 1'b1;
          end else begin
            state_nxt = S_LO;
          end
        end
      end
      S_LO: begin
        if (xfer_done) begin
          if (kind_q == ACC_WORD) begin
            state_nxt = S_HI;
          end else begin
            state_nxt = S_DONE;
            load_out  = 1'b1;
            rdata_nxt = we_q ? 16'h0000 : {8'h00, bus_rdata};
          end
        end else if (xfer_timeout) begin
          state_nxt = S_DONE;
          load_out  = 1'b1;
          err_nxt   = 1'b1;
        end
      end
      S_HI: begin
        if (xfer_done) begin
          state_nxt = S_DONE;
          load_out  = 1'b1;
          rdata_nxt = we_q ? 16'h0000 : {bus_rdata, rdata_lo};
        end else if (xfer_timeout) begin
          state_nxt = S_DONE;
          load_out  = 1'b1;
          err_nxt   = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= S_IDLE;
      ctrl_q              <= '0;
      imm_q               <= '0;
      pc_q                <= '0;
      data_q              <= '0;
      addr_q              <= '0;
      kind_q              <= ACC_NONE;
      we_q                <= 1'b0;
      rdata_lo            <= '0;
      control_signals_out <= '0;
      imm_out             <= '0;
      pc_out              <= '0;
      alu_result_out      <= '0;
      mem_rdata_out       <= '0;
      bus_err_out         <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        ctrl_q <= control_signals_in;
        imm_q  <= imm_in;
        pc_q   <= pc_in;
        data_q <= alu_result_in;
        addr_q <= rf_addrData;
        kind_q <= in_kind;
        we_q   <= in_we;
      end
      if (state == S_LO && xfer_done) rdata_lo <= bus_rdata;
      if (load_out) begin
        control_signals_out <= from_in ? control_signals_in : ctrl_q;
        imm_out             <= from_in ? imm_in : imm_q;
        pc_out              <= from_in ? pc_in : pc_q;
        alu_result_out      <= from_in ? alu_result_in : data_q;
        mem_rdata_out       <= rdata_nxt;
        bus_err_out         <= err_nxt;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a small req/ack bus responder and transfer log.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [32:0] control_signals_in;
  logic [15:0] imm_in, pc_in, alu_result_in;
  logic [2:0]  rf_regAddr;
  logic [15:0] rf_addrData;
  logic        bus_req, bus_we, bus_ack;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata, bus_rdata;
  logic        out_valid;
  logic [32:0] control_signals_out;
  logic [15:0] imm_out, pc_out, alu_result_out, mem_rdata_out;
  logic        bus_err_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage #(.WAIT_LIMIT(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .control_signals_in(control_signals_in), .imm_in(imm_in), .pc_in(pc_in),
    .alu_result_in(alu_result_in), .rf_regAddr(rf_regAddr), .rf_addrData(rf_addrData),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .out_valid(out_valid),
    .control_signals_out(control_signals_out), .imm_out(imm_out), .pc_out(pc_out),
    .alu_result_out(alu_result_out), .mem_rdata_out(mem_rdata_out), .bus_err_out(bus_err_out)
  );

  logic [15:0] regs [0:7];
  assign rf_addrData = regs[rf_regAddr];

  // Responder: ack once a request has waited ack_lat cycles.
  int   ack_lat;
  logic ack_en;
  int   wait_cnt = 0;
  int   req_cycles = 0;
  int   ov_count = 0;
  logic [15:0] xf_addr [$];
  logic [7:0]  xf_wdata [$];
  logic        xf_we [$];

  assign bus_ack   = ack_en && bus_req && (wait_cnt >= ack_lat);
  assign bus_rdata = (bus_addr == 16'h1000) ? 8'h34 :
                     (bus_addr == 16'h1001) ? 8'h12 : (bus_addr[7:0] ^ 8'h5A);

  always @(posedge clk) begin
    if (bus_req && !bus_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
    if (bus_req) req_cycles <= req_cycles + 1;
    if (out_valid) ov_count <= ov_count + 1;
    if (bus_req && bus_ack) begin
      xf_addr.push_back(bus_addr);
      xf_wdata.push_back(bus_wdata);
      xf_we.push_back(bus_we);
    end
  end

  logic ir_hist [0:63];

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [32:0] mk_ctrl(input logic [2:0] ra, input logic rb, input logic rw,
                                          input logic wb, input logic ww, input logic [25:0] hi);
    logic [32:0] c;
    c = '0;
    c[32:7] = hi;
    c[CW_REG_ADDR +: 3] = ra;
    c[CW_MEM_READ_B]  = rb;
    c[CW_MEM_READ_W]  = rw;
    c[CW_MEM_WRITE_B] = wb;
    c[CW_MEM_WRITE_W] = ww;
    return c;
  endfunction

  // Called #1 after an edge with the DUT idle; returns #1 after the accepting edge.
  task automatic issue(input logic [32:0] c, input logic [15:0] i, input logic [15:0] p,
                       input logic [15:0] a);
    in_valid = 1'b1;
    control_signals_in = c;
    imm_in = i;
    pc_in = p;
    alu_result_in = a;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      ir_hist[k] = in_ready;
      if (out_valid) begin
        lat = k;
        break;
      end
      step();
    end
    if (lat < 0) check_eq("out_valid_wait_expired", 64'd0, 64'd1);
  endtask

  int lat, ov0, rq0, xb;
  logic [32:0] c;

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    control_signals_in = '0;
    imm_in = '0;
    pc_in = '0;
    alu_result_in = '0;
    ack_en = 1'b1;
    ack_lat = 0;
    for (int r = 0; r < 8; r++) regs[r] = 16'h0000;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_bus_req", bus_req, 0);
    check_eq("rst_rdata", mem_rdata_out, 0);
    check_eq("rst_ctrl_out", control_signals_out, 0);
    reset = 1'b0;
    step();
    check_eq("post_rst_in_ready", in_ready, 1);

    // No-mem instruction
    c = mk_ctrl(3'd0, 0, 0, 0, 0, 26'h2AA_AAAA);
    ov0 = ov_count; rq0 = req_cycles;
    issue(c, 16'h1111, 16'h0040, 16'h2222);
    wait_done(lat);
    check_eq("nomem_lat", lat, 1);
    check_eq("nomem_pc", pc_out, 16'h0040);
    check_eq("nomem_imm", imm_out, 16'h1111);
    check_eq("nomem_alu", alu_result_out, 16'h2222);
    check_eq("nomem_ctrl", control_signals_out, c);
    check_eq("nomem_rdata", mem_rdata_out, 0);
    check_eq("nomem_req", req_cycles - rq0, 0);
    step();
    check_eq("nomem_pulse", out_valid, 0);
    check_eq("nomem_ov_count", ov_count - ov0, 1);

    // Word read, 2-cycle ack latency per byte
    regs[1] = 16'h1000; ack_lat = 2;
    c = mk_ctrl(3'd1, 0, 1, 0, 0, 26'h000_0123);
    xb = xf_addr.size();
    issue(c, 16'h0001, 16'h0044, 16'h7777);
    wait_done(lat);
    check_eq("wrd_lat", lat, 7);
    check_eq("wrd_nxf", xf_addr.size() - xb, 2);
    if (xf_addr.size() >= xb + 2) begin
      check_eq("wrd_addr0", xf_addr[xb], 16'h1000);
      check_eq("wrd_addr1", xf_addr[xb+1], 16'h1001);
      check_eq("wrd_we0", xf_we[xb], 0);
    end
    check_eq("wrd_rdata", mem_rdata_out, 16'h1234);
    check_eq("wrd_err", bus_err_out, 0);
    check_eq("wrd_ctrl", control_signals_out, c);
    step();

    // Byte write (read flag also set, write wins), immediate ack
    regs[2] = 16'h0200; ack_lat = 0;
    c = mk_ctrl(3'd2, 0, 1, 1, 0, 26'h155_0000);
    xb = xf_addr.size();
    issue(c, 16'h0002, 16'h0048, 16'hABCD);
    wait_done(lat);
    check_eq("bw_lat", lat, 2);
    check_eq("bw_ready_n1", ir_hist[1], 0);
    check_eq("bw_ready_n2", in_ready, 0);
    check_eq("bw_nxf", xf_addr.size() - xb, 1);
    if (xf_addr.size() >= xb + 1) begin
      check_eq("bw_addr", xf_addr[xb], 16'h0200);
      check_eq("bw_wdata", xf_wdata[xb], 8'hCD);
      check_eq("bw_we", xf_we[xb], 1);
    end
    check_eq("bw_rdata", mem_rdata_out, 0);
    check_eq("bw_alu", alu_result_out, 16'hABCD);
    step();
    check_eq("bw_ready_after", in_ready, 1);

    // Word write across the address wrap (W beats B)
    regs[3] = 16'hFFFF;
    c = mk_ctrl(3'd3, 0, 0, 1, 1, 26'h0);
    xb = xf_addr.size();
    issue(c, 16'h0003, 16'h004C, 16'h5566);
    wait_done(lat);
    check_eq("ww_lat", lat, 3);
    check_eq("ww_nxf", xf_addr.size() - xb, 2);
    if (xf_addr.size() >= xb + 2) begin
      check_eq("ww_addr0", xf_addr[xb], 16'hFFFF);
      check_eq("ww_wdata0", xf_wdata[xb], 8'h66);
      check_eq("ww_addr1", xf_addr[xb+1], 16'h0000);
      check_eq("ww_wdata1", xf_wdata[xb+1], 8'h55);
      check_eq("ww_we1", xf_we[xb+1], 1);
    end
    step();

    // Timeout with WAIT_LIMIT = 4
    ack_en = 1'b0;
    regs[4] = 16'h3000;
    c = mk_ctrl(3'd4, 1, 1, 0, 0, 26'h0);
    rq0 = req_cycles;
    issue(c, 16'h0004, 16'h0050, 16'h0000);
    wait_done(lat);
    check_eq("to_lat", lat, 5);
    check_eq("to_req_cycles", req_cycles - rq0, 4);
    check_eq("to_err", bus_err_out, 1);
    check_eq("to_rdata", mem_rdata_out, 0);
    step();
    ack_en = 1'b1;
    regs[5] = 16'h0010;
    c = mk_ctrl(3'd5, 1, 0, 0, 0, 26'h0);
    issue(c, 16'h0005, 16'h0054, 16'h0000);
    wait_done(lat);
    check_eq("after_to_lat", lat, 2);
    check_eq("after_to_rdata", mem_rdata_out, 16'h004A);
    check_eq("after_to_err", bus_err_out, 0);
    step();

    // Reset during HI of a word read
    ack_lat = 2;
    regs[6] = 16'h4000;
    c = mk_ctrl(3'd6, 0, 1, 0, 0, 26'h0);
    ov0 = ov_count;
    issue(c, 16'h0006, 16'h0058, 16'h0000);
    for (int k = 0; k < 20 && bus_addr != 16'h4001; k++) step();
    check_eq("mr_reach_hi", bus_addr, 16'h4001);
    reset = 1'b1;
    step();
    check_eq("mr_bus_req", bus_req, 0);
    check_eq("mr_out_valid", out_valid, 0);
    check_eq("mr_in_ready", in_ready, 0);
    check_eq("mr_pc", pc_out, 0);
    check_eq("mr_ctrl", control_signals_out, 0);
    check_eq("mr_rdata", mem_rdata_out, 0);
    check_eq("mr_err", bus_err_out, 0);
    check_eq("mr_regaddr", rf_regAddr, 0);
    step();
    reset = 1'b0;
    repeat (3) step();
    check_eq("mr_no_ov", ov_count - ov0, 0);
    check_eq("mr_ready", in_ready, 1);
    ack_lat = 0;
    regs[7] = 16'h0021;
    c = mk_ctrl(3'd7, 1, 0, 0, 0, 26'h0);
    issue(c, 16'h0007, 16'h005C, 16'h0000);
    wait_done(lat);
    check_eq("mr_new_lat", lat, 2);
    check_eq("mr_new_rdata", mem_rdata_out, 16'h007B);
    check_eq("mr_new_pc", pc_out, 16'h005C);
    check_eq("mr_new_err", bus_err_out, 0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the ALU stage. It consumes the ALU stage's registered control word, immediate, PC and ALU result.
- Performs the instruction's data-memory access over an 8-bit request/acknowledge bus. Word accesses are split into two byte transfers, low byte first.
- Hands the completed instruction, with read data and error status, to writeback as a one-cycle out_valid pulse.
- Back-pressures the ALU stage through in_ready while an access is in flight.

Parameters:
- WAIT_LIMIT, 255: cycles one byte transfer may wait for bus_ack before abort; 0 disables the timeout.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > WAIT_LIMIT.

Ports:
- clk  in  1  clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  ALU stage presents an instruction.
- in_ready  out  1  stage accepts this cycle.
- control_signals_in  in  33  control word from the ALU stage.
- imm_in  in  16  immediate.
- pc_in  in  16  PC.
- alu_result_in  in  16  ALU result; store data.
- rf_regAddr  out  3  register-file read select for the address register (the decoded regAddr field).
- rf_addrData  in  16  address register contents; combinational read.
- bus_req  out  1  byte-transfer request.
- bus_we  out  1  1 = write.
- bus_addr  out  16  byte address.
- bus_wdata  out  8  write byte.
- bus_rdata  in  8  read byte; valid when bus_ack = 1.
- bus_ack  in  1  transfer complete this cycle.
- out_valid  out  1  one-cycle pulse: instruction done.
- control_signals_out  out  33  latched control word.
- imm_out  out  16  latched immediate.
- pc_out  out  16  latched PC.
- alu_result_out  out  16  latched ALU result.
- mem_rdata_out  out  16  load result.
- bus_err_out  out  1  access aborted by timeout.

Behaviour:
- Control-word fields regAddr, memReadB, memReadW, memWriteB and memWriteW come from the existing ctrl_decode.
- FSM states: IDLE, LO, HI, DONE.
- IDLE:
  - in_ready = 1 in IDLE and only in IDLE; it is forced to 0 while reset is high.
  - Acceptance happens when in_valid & in_ready. On acceptance, latch control_signals_in, imm_in, pc_in, alu_result_in and addr = rf_addrData (sampled the same cycle).
  - Next state is DONE if no mem flag is set; otherwise LO.
- Access-type priority:
  - A write flag beats a read flag; the read is ignored.
  - A W flag beats a B flag.
  - Word access is latched as "word"; otherwise "byte".
- LO:
  - bus_req = 1, bus_addr = addr, bus_we = write, bus_wdata = data[7:0].
  - On bus_ack: capture bus_rdata into rdata[7:0] and clear the wait counter. Next state is HI for a word access, otherwise DONE.
- HI:
  - bus_req = 1, bus_addr = addr + 1 (16-bit wrap: 0xFFFF -> 0x0000), bus_wdata = data[15:8].
  - On bus_ack: capture bus_rdata into rdata[15:8]; next state DONE.
- Bus handshake:
  - Each cycle in which bus_req = 1 and bus_ack = 1 completes exactly one transfer.
  - bus_req may stay high across the LO -> HI move; bus_addr and bus_wdata change on that edge.
  - bus_ack while in IDLE or DONE is ignored.
  - bus_* are decoded from state and latched registers. Outside LO/HI: bus_req = 0, bus_we = 0, bus_addr = 0, bus_wdata = 0.
- Timeout:
  - The wait counter increments each LO/HI cycle without ack.
  - When WAIT_LIMIT != 0 and the counter reaches WAIT_LIMIT without ack: go to DONE and set an error flag.
  - On abort, mem_rdata_out = 0.
- DONE:
  - out_valid = 1 for exactly one cycle.
  - The registered outputs update on entry to DONE and hold until the next entry.
  - Next state is IDLE.
  - There is no bypass back-to-back: after DONE, a new instruction is accepted no earlier than the following IDLE cycle.
- Load result:
  - Byte read: mem_rdata_out = {8'h00, rdata[7:0]}.
  - Word read: mem_rdata_out = {rdata[15:8], rdata[7:0]} (little-endian).
  - Writes and non-mem instructions: mem_rdata_out = 0.
- Latency from the acceptance cycle N:
  - No-mem instruction: out_valid at N+1.
  - Byte access with ack on the first LO cycle: out_valid at N+2.
  - Word access with immediate acks: out_valid at N+3.
- Reset values: the FSM returns to IDLE, all counters and registers clear, and every output is 0 (in_ready = 0 while reset is high).
- Reset mid-transfer: the transfer is dropped and bus_req = 0 from the cycle after the reset edge. No out_valid is produced for the dropped instruction.

Decomposition:
- Shared package: FSM state encoding (IDLE/LO/HI/DONE), the access-kind enum (NONE/BYTE/WORD), and the bus byte-lane constants (LO = 0, HI = 1).
- Sub-modules: reuse ctrl_decode for the field extraction. The one natural new sub-module is mem_byte_xfer (a single byte transfer with its wait counter and timeout), instantiated once and sequenced by the FSM.

Test Plan:
- No-mem instruction, pc_in = 0x0040 -> out_valid at N+1, pc_out = 0x0040, mem_rdata_out = 0, bus_req never 1.
- Word read, addr 0x1000, bus returns 0x34 then 0x12 with 2-cycle ack latency each -> bus_addr 0x1000 then 0x1001, mem_rdata_out = 0x1234, bus_err_out = 0.
- Byte write, alu_result_in = 0xABCD, addr 0x0200, immediate ack -> one transfer: bus_we = 1, bus_wdata = 0xCD; out_valid at N+2; in_ready = 0 from N+1 to N+2.
- Word write at addr 0xFFFF, data 0x5566 -> transfers 0x66 @ 0xFFFF, then 0x55 @ 0x0000.
- WAIT_LIMIT = 4, no ack -> bus_req high for 4 cycles, then out_valid with bus_err_out = 1 and mem_rdata_out = 0; the next instruction is accepted normally.
- Reset asserted during HI of a word read -> bus_req = 0 the next cycle, no out_valid, all outputs 0; after reset, in_ready = 1 and a new byte read completes correctly.
